// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the codec DAC: buffers up to two stereo frames and shifts
// them out MSB-first on the generator's Bfall/LRfall/LRrise strobes.
module i2s_dac_tx #(
    parameter int SAMPLE_W = 16
) (
    input  logic                CLK_IN,
    input  logic                reset,
    input  logic                Bfall,
    input  logic                LRfall,
    input  logic                LRrise,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                DOUT,
    output logic                underrun,
    output logic [7:0]          underrun_cnt,
    output logic [1:0]          fifo_level
);

    // Places a sample at the top of a 32-bit slot; unused low bits are zero.
    function automatic logic [31:0] justify(input logic [SAMPLE_W-1:0] sample);
        logic [31:0] slot;
        slot = 32'd0;
        slot[31 -: SAMPLE_W] = sample;
        return slot;
    endfunction

    logic [SAMPLE_W-1:0] left_mem_r  [2];
    logic [SAMPLE_W-1:0] right_mem_r [2];
    logic                wr_ptr_r;
    logic                rd_ptr_r;
    logic [1:0]          level_r;
    logic [31:0]         shifter_r;
    logic [SAMPLE_W-1:0] r_hold_r;
    logic                dout_r;
    logic                underrun_r;
    logic [7:0]          underrun_cnt_r;

    logic                push_s;
    logic                pop_s;
    logic [1:0]          level_nxt_s;
    logic [31:0]         shifter_nxt_s;
    logic [SAMPLE_W-1:0] r_hold_nxt_s;
    logic                dout_nxt_s;
    logic                underrun_nxt_s;
    logic [7:0]          underrun_cnt_nxt_s;

    assign in_ready     = (level_r != 2'd2);
    assign push_s       = in_valid && in_ready;
    assign pop_s        = LRfall && (level_r != 2'd0);
    assign DOUT         = dout_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = underrun_cnt_r;
    assign fifo_level   = level_r;

    // Buffer occupancy: a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + 2'd1;
            2'b01:   level_nxt_s = level_r - 2'd1;
            default: level_nxt_s = level_r;
        endcase
    end

    // Slot loading and bit shifting; a load strobe always beats a coincident Bfall.
    always_comb begin
        shifter_nxt_s      = shifter_r;
        r_hold_nxt_s       = r_hold_r;
        dout_nxt_s         = dout_r;
        underrun_nxt_s     = 1'b0;
        underrun_cnt_nxt_s = underrun_cnt_r;
        if (LRfall) begin
            if (level_r != 2'd0) begin
                shifter_nxt_s = justify(left_mem_r[rd_ptr_r]);
                r_hold_nxt_s  = right_mem_r[rd_ptr_r];
            end else begin
                shifter_nxt_s  = 32'd0;
                r_hold_nxt_s   = '0;
                underrun_nxt_s = 1'b1;
                if (underrun_cnt_r != 8'd255) begin
                    underrun_cnt_nxt_s = underrun_cnt_r + 8'd1;
                end else begin
                    underrun_cnt_nxt_s = underrun_cnt_r;
                end
            end
        end else if (LRrise) begin
            shifter_nxt_s = justify(r_hold_r);
        end else if (Bfall) begin
            dout_nxt_s    = shifter_r[31];
            shifter_nxt_s = {shifter_r[30:0], 1'b0};
        end else begin
            shifter_nxt_s = shifter_r;
        end
    end

    // Frame storage and pointers.
    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            left_mem_r[0]  <= '0;
            left_mem_r[1]  <= '0;
            right_mem_r[0] <= '0;
            right_mem_r[1] <= '0;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            level_r        <= 2'd0;
        end else begin
            if (push_s) begin
                left_mem_r[wr_ptr_r]  <= in_left;
                right_mem_r[wr_ptr_r] <= in_right;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            level_r <= level_nxt_s;
        end
    end

    // Serialiser and underrun status registers.
    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            shifter_r      <= 32'd0;
            r_hold_r       <= '0;
            dout_r         <= 1'b0;
            underrun_r     <= 1'b0;
            underrun_cnt_r <= 8'd0;
        end else begin
            shifter_r      <= shifter_nxt_s;
            r_hold_r       <= r_hold_nxt_s;
            dout_r         <= dout_nxt_s;
            underrun_r     <= underrun_nxt_s;
            underrun_cnt_r <= underrun_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: a 16-bit instance for the main behaviour and a
// 24-bit instance sharing the strobes for the slot-width case.
module tb_i2s_dac_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        Bfall, LRfall, LRrise;
    logic [15:0] in_left, in_right;
    logic        in_valid;
    logic        in_ready, DOUT, underrun;
    logic [7:0]  underrun_cnt;
    logic [1:0]  fifo_level;

    logic [23:0] in_left2, in_right2;
    logic        in_valid2;
    logic        in_ready2, dout2, underrun2;
    logic [7:0]  underrun_cnt2;
    logic [1:0]  fifo_level2;

    int pass_cnt = 0;
    int total_cnt = 0;
    int underrun_seen = 0;
    int base;
    logic [31:0] w1, w2;
    logic b1, b2;
    logic [4:0] first5;

    always #5 clk = ~clk;

    i2s_dac_tx #(.SAMPLE_W(16)) dut (
        .CLK_IN(clk), .reset(reset), .Bfall(Bfall), .LRfall(LRfall), .LRrise(LRrise),
        .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(in_ready),
        .DOUT(DOUT), .underrun(underrun), .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
    );

    i2s_dac_tx #(.SAMPLE_W(24)) dut24 (
        .CLK_IN(clk), .reset(reset), .Bfall(Bfall), .LRfall(LRfall), .LRrise(LRrise),
        .in_left(in_left2), .in_right(in_right2), .in_valid(in_valid2), .in_ready(in_ready2),
        .DOUT(dout2), .underrun(underrun2), .underrun_cnt(underrun_cnt2), .fifo_level(fifo_level2)
    );

    always @(negedge clk) begin
        if (underrun) underrun_seen <= underrun_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bclk(output logic o1, output logic o2);
        Bfall = 1'b1;
        @(negedge clk);
        Bfall = 1'b0;
        o1 = DOUT;
        o2 = dout2;
        @(negedge clk);
    endtask

    task automatic shift32(output logic [31:0] o1, output logic [31:0] o2);
        logic x1, x2;
        o1 = 32'd0;
        o2 = 32'd0;
        for (int i = 0; i < 32; i++) begin
            bclk(x1, x2);
            o1 = {o1[30:0], x1};
            o2 = {o2[30:0], x2};
        end
    endtask

    task automatic lr(input bit left);
        if (left) LRfall = 1'b1;
        else      LRrise = 1'b1;
        @(negedge clk);
        LRfall = 1'b0;
        LRrise = 1'b0;
        @(negedge clk);
    endtask

    task automatic slot(input bit left, output logic [31:0] o1, output logic [31:0] o2);
        lr(left);
        shift32(o1, o2);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Bfall = 1'b0; LRfall = 1'b0; LRrise = 1'b0;
        in_left = 16'd0; in_right = 16'd0; in_valid = 1'b0;
        in_left2 = 24'd0; in_right2 = 24'd0; in_valid2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", {31'd0, DOUT}, 32'd0);
        check("rst_level", {30'd0, fifo_level}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_cnt", {24'd0, underrun_cnt}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame
        push(16'hA5C3, 16'h1234);
        check("basic_level1", {30'd0, fifo_level}, 32'd1);
        slot(1'b1, w1, w2);
        check("basic_left", w1, 32'hA5C3_0000);
        check("basic_level0", {30'd0, fifo_level}, 32'd0);
        slot(1'b0, w1, w2);
        check("basic_right", w1, 32'h1234_0000);
        check("basic_no_underrun", {24'd0, underrun_cnt}, 32'd0);

        // Back-pressure
        in_left = 16'h1111; in_right = 16'h2222; in_valid = 1'b1;
        @(negedge clk);
        in_left = 16'h3333; in_right = 16'h4444;
        @(negedge clk);
        in_left = 16'h5555; in_right = 16'h6666;
        @(negedge clk);
        check("bp_level2", {30'd0, fifo_level}, 32'd2);
        check("bp_not_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("bp_held", {30'd0, fifo_level}, 32'd2);
        LRfall = 1'b1;
        @(negedge clk);
        LRfall = 1'b0;
        check("bp_pop_level", {30'd0, fifo_level}, 32'd1);
        check("bp_pop_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_third_accepted", {30'd0, fifo_level}, 32'd2);
        shift32(w1, w2);
        check("bp_a_left", w1, 32'h1111_0000);
        slot(1'b0, w1, w2);
        check("bp_a_right", w1, 32'h2222_0000);
        slot(1'b1, w1, w2);
        check("bp_b_left", w1, 32'h3333_0000);
        slot(1'b1, w1, w2);
        check("bp_c_left", w1, 32'h5555_0000);
        check("bp_empty", {30'd0, fifo_level}, 32'd0);

        // Underrun
        base = underrun_seen;
        for (int i = 0; i < 3; i++) begin
            slot(1'b1, w1, w2);
            check("ur_dout_zero", w1, 32'd0);
        end
        check("ur_pulses", underrun_seen - base, 32'd3);
        check("ur_cnt3", {24'd0, underrun_cnt}, 32'd3);
        for (int i = 0; i < 300; i++) lr(1'b1);
        check("ur_cnt_sat", {24'd0, underrun_cnt}, 32'd255);

        // Simultaneous push/pop, also with a colliding Bfall
        push(16'hD00D, 16'hD11D);
        in_left = 16'hE00E; in_right = 16'hE11E; in_valid = 1'b1;
        LRfall = 1'b1; Bfall = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; LRfall = 1'b0; Bfall = 1'b0;
        check("pp_level", {30'd0, fifo_level}, 32'd1);
        @(negedge clk);
        shift32(w1, w2);
        check("pp_old_left", w1, 32'hD00D_0000);
        slot(1'b0, w1, w2);
        check("pp_old_right", w1, 32'hD11D_0000);
        slot(1'b1, w1, w2);
        check("pp_new_left", w1, 32'hE00E_0000);

        // Reset mid-slot
        push(16'hFFFF, 16'hFFFF);
        push(16'hFFFF, 16'hFFFF);
        lr(1'b1);
        for (int i = 0; i < 5; i++) begin
            bclk(b1, b2);
            first5 = {first5[3:0], b1};
        end
        check("mr_first5", {27'd0, first5}, 32'h1F);
        reset = 1'b1;
        #1;
        check("mr_dout", {31'd0, DOUT}, 32'd0);
        check("mr_level", {30'd0, fifo_level}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        shift32(w1, w2);
        check("mr_no_stray", w1, 32'd0);
        slot(1'b1, w1, w2);
        check("mr_empty_slot", w1, 32'd0);
        check("mr_cnt", {24'd0, underrun_cnt}, 32'd1);
        push(16'h8421, 16'h0F0F);
        slot(1'b1, w1, w2);
        check("mr_next_frame", w1, 32'h8421_0000);

        // 24-bit slot width
        in_left2 = 24'h800001; in_right2 = 24'h7FFFFF; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        slot(1'b1, w1, w2);
        check("w24_left", w2, 32'h8000_0100);
        slot(1'b0, w1, w2);
        check("w24_right", w2, 32'h7FFF_FF00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
